// File: rtl/moore_seq_ctrl.sv
// moore_seq_ctrl: streams a parallel word MSB-first into a bit-serial Moore
// detector, collects the detector output after every bit into y_word, and
// reports the result and its population count with a busy/done handshake.
module moore_seq_ctrl #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  data_in,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic          det_rst,
  output logic          det_x,
  input  logic          det_y,
  output logic [W-1:0]  y_word,
  output logic [CW-1:0] ones_cnt
);

  localparam int KW = $clog2(W);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  sreg_q, sreg_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  y_word_q, y_word_d;
  logic [CW-1:0] ones_q, ones_d;
  logic          aborted_q, aborted_d;

  // Count update that can never run past W, whatever the detector does.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt, input logic bit_in);
    logic [CW-1:0] res;
    res = cnt;
    if (bit_in && (cnt < CW'(W)))
      res = cnt + CW'(1);
    return res;
  endfunction

  // State, datapath and pulse registers; rst returns everything to idle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sreg_q    <= '0;
      k_q       <= '0;
      y_word_q  <= '0;
      ones_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      k_q       <= k_d;
      y_word_q  <= y_word_d;
      ones_q    <= ones_d;
      aborted_q <= aborted_d;
    end
  end

  // Next-state logic: load, clear detector, shift W bits, drain last sample, report.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    k_d       = k_q;
    y_word_d  = y_word_q;
    ones_d    = ones_q;
    aborted_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // start beats a simultaneous abort; abort alone is ignored here
        if (start) begin
          sreg_d   = data_in;
          y_word_d = '0;
          ones_d   = '0;
          k_d      = '0;
          state_d  = ST_CLR;
        end
      end

      ST_CLR: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          k_d     = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          sreg_d = {sreg_q[W-2:0], 1'b0};
          // det_y now reflects the bit sent in the previous cycle (k-1),
          // which belongs at y_word[W-k]; nothing to capture at k=0
          if (k_q != '0) begin
            for (int i = 1; i < W; i++) begin
              if (int'(k_q) == (W - i))
                y_word_d[i] = det_y;
            end
            ones_d = sat_inc(ones_q, det_y);
          end
          if (k_q == KW'(W - 1)) begin
            state_d = ST_DRAIN;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end

      ST_DRAIN: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          // response to the last streamed bit
          y_word_d[0] = det_y;
          ones_d      = sat_inc(ones_q, det_y);
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign aborted  = aborted_q;
  assign det_rst  = (state_q == ST_CLR);
  assign det_x    = (state_q == ST_SHIFT) && sreg_q[W-1];
  assign y_word   = y_word_q;
  assign ones_cnt = ones_q;

endmodule
